// File: rtl/ahb_dmem_responder.sv
// AHB3-Lite data-memory responder for the LSU data port.
// Word RAM with wait states, two-cycle ERROR and a sticky protocol flag.
module ahb_dmem_responder #(
  parameter int unsigned MEM_SIZE    = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [31:0] s_hwdata_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o,
  output logic        s_proto_err_o
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / 4;
  localparam logic [2:0] WS_LD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [31:0] mem [WORDS];

  logic          dp_valid_q;
  logic          dp_write_q;
  logic [1:0]    dp_size_q;
  logic [1:0]    dp_lane_q;
  logic [AW-3:0] dp_widx_q;
  logic [31:0]   rdata_q;
  logic          proto_q;

  logic        p_low_q;
  logic        p_hsel_q;
  logic [1:0]  p_htrans_q;
  logic [31:0] p_haddr_q;
  logic        p_hwrite_q;
  logic [2:0]  p_hsize_q;

  logic          ready;
  logic          accept;
  logic          bad;
  logic          commit;
  logic [31:0]   offset;
  logic [AW-3:0] a_widx;
  logic [3:0]    wr_be;
  logic [31:0]   fwd;
  logic          nonseq_idle;
  logic          fld_chg;
  logic          proto_viol;

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign offset = s_haddr_i - BASE_ADDR;
  assign a_widx = offset[AW-1:2];
  assign accept = s_hsel_i && s_htrans_i[1] && s_hready_i && ready;

  assign bad = (offset >= 32'(MEM_SIZE))
            || (s_hsize_i > 3'd2)
            || ((s_hsize_i == 3'd1) && s_haddr_i[0])
            || ((s_hsize_i == 3'd2) && (s_haddr_i[1:0] != 2'b00));

  // A pending data phase finishes in the first ST_IDLE cycle after it.
  assign commit = !s_reset_i && (state_q == ST_IDLE)
               && dp_valid_q && dp_write_q;

  always_comb begin
    wr_be = 4'b0000;
    unique case (1'b1)
      dp_size_q == 2'd0: wr_be = 4'b0001 << dp_lane_q;
      dp_size_q == 2'd1: wr_be = dp_lane_q[1] ? 4'b1100 : 4'b0011;
      default:           wr_be = 4'b1111;
    endcase
  end

  // Merge lanes committed on this edge so a back-to-back read sees them.
  always_comb begin
    fwd = mem[a_widx];
    for (int i = 0; i < 4; i++) begin
      if (commit && wr_be[i] && (dp_widx_q == a_widx))
        fwd[8*i +: 8] = s_hwdata_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (bad) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LD;
          end
        end
      end
    endcase
  end

  assign nonseq_idle = (p_htrans_q == 2'b10) && (s_htrans_i == 2'b00);
  assign fld_chg = (s_htrans_i != 2'b00)
                && ((s_haddr_i != p_haddr_q)
                 || (s_hwrite_i != p_hwrite_q)
                 || (s_hsize_i != p_hsize_q));
  assign proto_viol = p_low_q && p_hsel_q && p_htrans_q[1]
                   && (nonseq_idle || fld_chg);

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      dp_valid_q <= 1'b0;
      rdata_q    <= 32'd0;
      proto_q    <= 1'b0;
      p_low_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_low_q <= !s_hreadyout_o;
      if (ready) dp_valid_q <= accept && !bad;
      if (accept && !bad && !s_hwrite_i) rdata_q <= fwd;
      if (proto_viol) proto_q <= 1'b1;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (accept && !bad) begin
      dp_write_q <= s_hwrite_i;
      dp_size_q  <= s_hsize_i[1:0];
      dp_lane_q  <= s_haddr_i[1:0];
      dp_widx_q  <= a_widx;
    end
    p_hsel_q   <= s_hsel_i;
    p_htrans_q <= s_htrans_i;
    p_haddr_q  <= s_haddr_i;
    p_hwrite_q <= s_hwrite_i;
    p_hsize_q  <= s_hsize_i;
  end

  always_ff @(posedge s_clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && wr_be[i])
        mem[dp_widx_q][8*i +: 8] <= s_hwdata_i[8*i +: 8];
    end
  end

  assign s_hreadyout_o = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign s_hresp_o     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign s_hrdata_o    = rdata_q;
  assign s_proto_err_o = proto_q;

endmodule

// File: doc/ahb_dmem_responder.md
Name: ahb_dmem_responder

Overview:
- AHB3-Lite single-port data-memory responder: the slave end of the core's data-bus initiator (LSU address/data phases).
- Serves word, halfword and byte loads and stores with a configurable number of wait states.
- Issues the two-cycle ERROR response for out-of-range, misaligned or illegal-size transfers.
- Flags initiator protocol violations during wait states, including the NONSEQ->IDLE change in a delayed transfer.
- Used as the data-side memory in the core testbench and the SoC wrapper.

Parameters:
- MEM_SIZE, 4096, memory size in bytes; a power of two, multiple of 4.
- BASE_ADDR, 32'h0000_0000, byte address of memory word 0.
- WAIT_STATES, 1, number of HREADYOUT-low cycles inserted per OKAY transfer; range 0..7.

Ports:
- s_clk_i  input  1  clock.
- s_reset_i  input  1  synchronous reset, active-high.
- s_hsel_i  input  1  slave select.
- s_haddr_i  input  32  address.
- s_htrans_i  input  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- s_hwrite_i  input  1  1 = write.
- s_hsize_i  input  3  transfer size (0=byte, 1=half, 2=word).
- s_hwdata_i  input  32  write data, valid in the data phase.
- s_hready_i  input  1  bus HREADY.
- s_hrdata_o  output  32  read data.
- s_hreadyout_o  output  1  transfer done.
- s_hresp_o  output  1  0 = OKAY, 1 = ERROR.
- s_proto_err_o  output  1  sticky protocol-violation flag.

Behaviour:
- One clock, s_clk_i. Reset is synchronous and active-high on s_reset_i.
- Reset values: s_hreadyout_o=1, s_hresp_o=0, s_hrdata_o=0, s_proto_err_o=0, FSM=ST_IDLE. Memory contents are not reset.
- Address-phase accept: at a rising edge with s_hsel_i & s_htrans_i[1] & s_hready_i. Latch addr, size, write, offset = addr-BASE_ADDR. BUSY and IDLE are accepted with no data phase; they leave an ST_IDLE responder in ST_IDLE with OKAY, zero wait.
- Error check at accept: ERROR when any of the following holds:
  - offset >= MEM_SIZE (unsigned, 32-bit compare);
  - hsize > 2;
  - hsize=1 with addr[0]=1;
  - hsize=2 with addr[1:0]!=0.
- FSM states and transitions:
  - ST_IDLE: hreadyout=1, hresp=0.
    - On an accepted legal transfer: go to ST_WAIT when WAIT_STATES>0; else the data phase completes in the next cycle, staying in ST_IDLE/OKAY.
    - On an accepted illegal transfer: go to ST_ERR1.
  - ST_WAIT: hreadyout=0, hresp=0. A counter loads WAIT_STATES-1 and decrements. At 0, return to ST_IDLE; the following cycle is the completing cycle with hreadyout=1.
  - Total data-phase length is exactly WAIT_STATES+1 cycles.
  - ST_ERR1: hreadyout=0, hresp=1. Always go to ST_ERR2.
  - ST_ERR2: hreadyout=1, hresp=1. Go to ST_IDLE, or apply the accept rule for a new transfer presented this cycle. Wait states are never inserted for ERROR.
- Back-to-back transfers: a new address phase may be accepted on the same edge the previous data phase completes (pipelined).
- Write commit: at the completing edge of an OKAY write data phase, write s_hwdata_i to the byte lanes selected by size and addr[1:0]:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all 4 lanes.
- ERROR writes never modify memory.
- Read data: s_hrdata_o is the full 32-bit word at offset[.. :2], valid on the completing cycle. Lane extraction and sign extension are the initiator's job.
- Read-after-write hazard: a read accepted on the edge that commits a write to the same word must return the merged new bytes. Implement this by forwarding the committed lanes into the read register.
- s_hrdata_o holds its last value outside read data phases and after ERROR.
- Protocol check, evaluated while s_hreadyout_o=0:
  - Address-phase signals (htrans, haddr, hwrite, hsize, hsel) must stay stable once htrans is non-IDLE.
  - A NONSEQ->IDLE change, or any change of haddr/hwrite/hsize with htrans non-IDLE, sets s_proto_err_o.
  - The flag stays set until reset. It does not alter the response.
- Reset mid-operation: reset in ST_WAIT/ST_ERR1/ST_ERR2 returns to ST_IDLE with reset output values next cycle. A pending write is dropped, not committed.

Test Plan:
- WAIT_STATES=1, write word 0xDEADBEEF to 0x10, then read 0x10 -> hreadyout low exactly 1 cycle per transfer, hresp=0, hrdata=0xDEADBEEF on the read completing cycle.
- WAIT_STATES=0, back-to-back write byte 0xAA at 0x21 then read word 0x20 (word preset 0x11223344) -> read returns 0x1122AA44 with no stall.
- Read 0x0000_2000 with MEM_SIZE=4096 -> hresp=1/hreadyout=0, then hresp=1/hreadyout=1, then OKAY idle; no memory change.
- Halfword write to 0x13 (misaligned), then word write 0x0 -> ERROR two-cycle response for the first; second completes OKAY; word at 0x10 unchanged.
- During a wait state, initiator changes htrans NONSEQ->IDLE -> s_proto_err_o=1 from the next cycle and stays 1 until s_reset_i; the transfer still completes normally.
- Assert s_reset_i during ST_WAIT of a write -> next cycle hreadyout=1, hresp=0, hrdata=0; target word retains its old value.
